// File: rtl/ahb_lite_mem_slave.sv
// rtl/ahb_lite_mem_slave.sv - AHB-Lite subordinate with wait states in front of a word-addressed memory
// Optional: `define AHB_MEM_SLAVE_ERR_RESP_EN for a two-cycle ERROR response on illegal transfers
module ahb_lite_mem_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned MEM_DEPTH   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [31:0] READ_addr,
  output logic        read_flag,
  input  logic [31:0] mem_rdata,
  output logic [31:0] WRITE_addr,
  output logic        write_flag,
  output logic [31:0] mem_wdata
);

`ifdef AHB_MEM_SLAVE_ERR_RESP_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;
`endif

  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(MEM_DEPTH) * 33'd4);

  state_t      r_state;
  logic        r_hreadyout;
  logic        r_hresp;
  logic        r_read_flag;
  logic        r_write_flag;
  logic        r_pend_write;
  logic        r_pend_legal;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_read_addr;
  logic [31:0] r_write_addr;
  logic [31:0] r_hrdata;

  logic        w_accept;
  logic        w_legal;
  logic [31:0] w_index;
  logic        w_unused;

  assign w_unused = HTRANS[0];
  // Only IDLE, ACCESS and ERR2 drive HREADYOUT high, so they are the only states that take a new address phase.
  assign w_accept = HSEL && HREADY && HTRANS[1] && r_hreadyout;
  assign w_legal  = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00) &&
                    (HADDR >= BASE_ADDR) && ({1'b0, HADDR} < LIMIT);
  assign w_index  = (HADDR - BASE_ADDR) >> 2;

  assign HREADYOUT  = r_hreadyout;
  assign HRESP      = r_hresp;
  assign read_flag  = r_read_flag;
  assign write_flag = r_write_flag;
  assign READ_addr  = r_read_addr;
  assign WRITE_addr = r_write_addr;
  assign mem_wdata  = r_write_flag ? HWDATA : 32'h0;

  always_comb begin
    HRDATA = r_hrdata;
    if (r_read_flag)
      HRDATA = mem_rdata;
    else if ((r_state == S_ACCESS) && !r_pend_legal && !r_pend_write)
      HRDATA = 32'h0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= S_IDLE;
      r_hreadyout  <= 1'b1;
      r_hresp      <= 1'b0;
      r_read_flag  <= 1'b0;
      r_write_flag <= 1'b0;
      r_pend_write <= 1'b0;
      r_pend_legal <= 1'b0;
      r_wait_cnt   <= '0;
      r_read_addr  <= '0;
      r_write_addr <= '0;
      r_hrdata     <= '0;
    end else begin
      if ((r_state == S_ACCESS) && !r_pend_write)
        r_hrdata <= HRDATA;
      r_read_flag  <= 1'b0;
      r_write_flag <= 1'b0;
      if (w_accept) begin
        r_pend_write <= HWRITE;
        r_pend_legal <= w_legal;
        r_wait_cnt   <= '0;
        if (w_legal && !HWRITE) r_read_addr  <= w_index;
        if (w_legal && HWRITE)  r_write_addr <= w_index;
`ifdef AHB_MEM_SLAVE_ERR_RESP_EN
        if (!w_legal) begin
          r_state     <= S_ERR1;
          r_hreadyout <= 1'b0;
          r_hresp     <= 1'b1;
        end else
`endif
        begin
          r_state      <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
          r_hreadyout  <= (WAIT_STATES == 0);
          r_hresp      <= 1'b0;
          r_read_flag  <= (WAIT_STATES == 0) && w_legal && !HWRITE;
          r_write_flag <= (WAIT_STATES == 0) && w_legal && HWRITE;
        end
      end else begin
        case (r_state)
          S_WAIT: begin
            if (r_wait_cnt == 4'(WAIT_STATES - 1)) begin
              r_state      <= S_ACCESS;
              r_hreadyout  <= 1'b1;
              r_read_flag  <= r_pend_legal && !r_pend_write;
              r_write_flag <= r_pend_legal && r_pend_write;
              r_wait_cnt   <= '0;
            end else begin
              r_wait_cnt <= r_wait_cnt + 4'd1;
            end
          end
`ifdef AHB_MEM_SLAVE_ERR_RESP_EN
          S_ERR1: begin
            r_state     <= S_ERR2;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b1;
          end
`endif
          default: begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// tb/tb_ahb_lite_mem_slave.sv - randomized self-checking bench, one instance with 0 and one with 1 wait state
module tb_ahb_lite_mem_slave;

`ifdef AHB_MEM_SLAVE_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int WS0 = 0;
  localparam int WS1 = 1;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk = 1'b0;
  logic        hreset [2];
  logic        hsel [2];
  logic [31:0] haddr [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize [2];
  logic [31:0] hwdata [2];
  logic        hready_en [2];
  logic        hready [2];
  logic        hreadyout [2];
  logic        hresp [2];
  logic [31:0] hrdata [2];
  logic [31:0] read_addr [2];
  logic        read_flag [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] write_addr [2];
  logic        write_flag [2];
  logic [31:0] mem_wdata [2];

  logic [31:0] ext_mem [2][4096];
  logic [31:0] ref_mem [2][4096];
  logic        load_mem = 1'b0;
  logic [31:0] last_rd [2];
  bit          hold_known [2];
  xfer_t       seq [$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign hready[g]    = hreadyout[g] & hready_en[g];
    assign mem_rdata[g] = ext_mem[g][read_addr[g][11:0]];
    ahb_lite_mem_slave #(.WAIT_STATES((g == 0) ? WS0 : WS1), .MEM_DEPTH(4096), .BASE_ADDR(32'h0)) u_dut (
      .HCLK(clk), .HRESET(hreset[g]), .HSEL(hsel[g]), .HADDR(haddr[g]), .HTRANS(htrans[g]),
      .HWRITE(hwrite[g]), .HSIZE(hsize[g]), .HWDATA(hwdata[g]), .HREADY(hready[g]),
      .HREADYOUT(hreadyout[g]), .HRESP(hresp[g]), .HRDATA(hrdata[g]), .READ_addr(read_addr[g]),
      .read_flag(read_flag[g]), .mem_rdata(mem_rdata[g]), .WRITE_addr(write_addr[g]),
      .write_flag(write_flag[g]), .mem_wdata(mem_wdata[g]));
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (load_mem) begin
        for (int i = 0; i < 4096; i++) ext_mem[k][i] <= ref_mem[k][i];
      end else if (write_flag[k] === 1'b1) begin
        ext_mem[k][write_addr[k][11:0]] <= mem_wdata[k];
      end
    end
  end

  function automatic bit is_legal(input xfer_t t);
    return (t.size == 3'b010) && (t.addr[1:0] == 2'b00) && (t.addr < 32'(4 * 4096));
  endfunction

  function automatic int xfer_len(input xfer_t t, input int ws);
    if (!is_legal(t) && ERR_EN) return 2;
    return ws + 1;
  endfunction

  function automatic xfer_t mk(input logic [31:0] addr, input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    xfer_t t;
    t.addr = addr; t.write = wr; t.size = size; t.wdata = wdata;
    return t;
  endfunction

  // Drives the queued transfers fully pipelined and checks every data-phase cycle against transfer-level rules.
  task automatic run_seq(input int k);
    int a, d, c, cyc, exp_cyc, len, ws;
    bit lg, last, rd_now, zero_now;
    logic [31:0] idx;
    ws = (k == 0) ? WS0 : WS1;
    a = 0; d = -1; c = 0; cyc = 0; exp_cyc = 1;
    foreach (seq[i]) exp_cyc += xfer_len(seq[i], ws);
    while ((a < seq.size() || d >= 0) && cyc < 400) begin
      @(posedge clk); #1;
      hsel[k] = 1'b1; hready_en[k] = 1'b1;
      if (a < seq.size()) begin
        htrans[k] = 2'b10; haddr[k] = seq[a].addr; hwrite[k] = seq[a].write; hsize[k] = seq[a].size;
      end else begin
        htrans[k] = 2'b00;
      end
      hwdata[k] = (d >= 0) ? seq[d].wdata : $urandom;
      #1; cyc++;
      if (d >= 0) begin
        lg = is_legal(seq[d]); len = xfer_len(seq[d], ws); last = (c == len - 1);
        idx = seq[d].addr >> 2;
        rd_now = lg && !seq[d].write && last;
        zero_now = !lg && !ERR_EN && !seq[d].write && last;
        n_vec++; if (hreadyout[k] !== last) begin n_err++; $display("FAIL hreadyout k=%0d addr=%h got=%b exp=%b", k, seq[d].addr, hreadyout[k], last); end
        n_vec++; if (hresp[k] !== (!lg && ERR_EN)) begin n_err++; $display("FAIL hresp k=%0d addr=%h got=%b exp=%b", k, seq[d].addr, hresp[k], !lg && ERR_EN); end
        n_vec++; if (write_flag[k] !== (lg && seq[d].write && last)) begin n_err++; $display("FAIL write_flag k=%0d addr=%h got=%b", k, seq[d].addr, write_flag[k]); end
        n_vec++; if (read_flag[k] !== rd_now) begin n_err++; $display("FAIL read_flag k=%0d addr=%h got=%b exp=%b", k, seq[d].addr, read_flag[k], rd_now); end
        if (lg && seq[d].write && last) begin
          n_vec++; if (write_addr[k] !== idx) begin n_err++; $display("FAIL write_addr k=%0d got=%h exp=%h", k, write_addr[k], idx); end
          n_vec++; if (mem_wdata[k] !== seq[d].wdata) begin n_err++; $display("FAIL mem_wdata k=%0d got=%h exp=%h", k, mem_wdata[k], seq[d].wdata); end
        end
        if (rd_now) begin
          n_vec++; if (read_addr[k] !== idx) begin n_err++; $display("FAIL read_addr k=%0d got=%h exp=%h", k, read_addr[k], idx); end
          n_vec++; if (hrdata[k] !== ref_mem[k][idx[11:0]]) begin n_err++; $display("FAIL hrdata k=%0d addr=%h got=%h exp=%h", k, seq[d].addr, hrdata[k], ref_mem[k][idx[11:0]]); end
        end else if (zero_now) begin
          n_vec++; if (hrdata[k] !== 32'h0) begin n_err++; $display("FAIL hrdata_illegal k=%0d got=%h exp=0", k, hrdata[k]); end
        end else if (hold_known[k]) begin
          n_vec++; if (hrdata[k] !== last_rd[k]) begin n_err++; $display("FAIL hrdata_hold k=%0d got=%h exp=%h", k, hrdata[k], last_rd[k]); end
        end
      end else begin
        n_vec++; if (hreadyout[k] !== 1'b1 || hresp[k] !== 1'b0) begin n_err++; $display("FAIL idle_resp k=%0d got=%b%b exp=10", k, hreadyout[k], hresp[k]); end
        n_vec++; if (write_flag[k] !== 1'b0 || read_flag[k] !== 1'b0) begin n_err++; $display("FAIL idle_strobe k=%0d got=%b%b exp=00", k, write_flag[k], read_flag[k]); end
      end
      if (hready[k] === 1'b1) begin
        if (d >= 0) begin
          if (seq[d].write) begin
            if (lg) ref_mem[k][idx[11:0]] = seq[d].wdata;
          end else if (lg) begin
            last_rd[k] = ref_mem[k][idx[11:0]]; hold_known[k] = 1'b1;
          end else begin
            hold_known[k] = 1'b0;
          end
        end
        if (a < seq.size()) begin d = a; a++; end else d = -1;
        c = 0;
      end else if (d >= 0) begin
        c++;
      end
    end
    n_vec++;
    if (cyc !== exp_cyc) begin n_err++; $display("FAIL seq_cycles k=%0d got=%0d exp=%0d", k, cyc, exp_cyc); end
    seq.delete();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      hreset[k] = 1'b1; hsel[k] = 1'b0; htrans[k] = 2'b00; haddr[k] = '0; hwrite[k] = 1'b0;
      hsize[k] = 3'b010; hwdata[k] = '0; hready_en[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (hreadyout[k] !== 1'b1 || hresp[k] !== 1'b0) begin n_err++; $display("FAIL reset_resp k=%0d got=%b%b exp=10", k, hreadyout[k], hresp[k]); end
      n_vec++; if (hrdata[k] !== 32'h0) begin n_err++; $display("FAIL reset_hrdata k=%0d got=%h exp=0", k, hrdata[k]); end
      n_vec++; if (read_flag[k] !== 1'b0 || write_flag[k] !== 1'b0) begin n_err++; $display("FAIL reset_flags k=%0d got=%b%b exp=00", k, read_flag[k], write_flag[k]); end
      n_vec++; if (read_addr[k] !== 32'h0 || write_addr[k] !== 32'h0 || mem_wdata[k] !== 32'h0) begin n_err++; $display("FAIL reset_addr k=%0d got=%h/%h/%h exp=0", k, read_addr[k], write_addr[k], mem_wdata[k]); end
      hreset[k] = 1'b0; last_rd[k] = 32'h0; hold_known[k] = 1'b1;
    end
  endtask

  task automatic test_write_read();
    seq.push_back(mk(32'h10, 1'b1, 3'b010, 32'hDEAD_BEEF));
    run_seq(1);
    repeat (2) @(posedge clk);
    seq.push_back(mk(32'h10, 1'b0, 3'b010, 32'h0));
    run_seq(1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      seq.push_back(mk(32'h20, 1'b1, 3'b010, 32'h1234_5678));
      seq.push_back(mk(32'h20, 1'b0, 3'b010, 32'h0));
      run_seq(k);
    end
  endtask

  task automatic test_pipelined_reads();
    for (int i = 0; i < 4; i++) seq.push_back(mk(32'(4 * i), 1'b0, 3'b010, 32'h0));
    run_seq(0);
  endtask

  task automatic test_errors();
    for (int k = 0; k < 2; k++) begin
      seq.push_back(mk(32'h4000, 1'b1, 3'b010, 32'hBAD0_0001));
      seq.push_back(mk(32'h4000, 1'b0, 3'b010, 32'h0));
      seq.push_back(mk(32'h13, 1'b0, 3'b010, 32'h0));
      seq.push_back(mk(32'h8, 1'b1, 3'b000, 32'hBAD0_0002));
      seq.push_back(mk(32'h8, 1'b0, 3'b010, 32'h0));
      run_seq(k);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h40; hwrite[1] = 1'b1; hsize[1] = 3'b010;
    @(posedge clk); #1;
    htrans[1] = 2'b00; hwdata[1] = 32'hFEED_0040; hreset[1] = 1'b1;
    #1;
    n_vec++; if (hreadyout[1] !== 1'b0) begin n_err++; $display("FAIL rst_mid_wait got=%b exp=0", hreadyout[1]); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      hreset[1] = 1'b0;
      #1;
      n_vec++; if (write_flag[1] !== 1'b0) begin n_err++; $display("FAIL rst_mid_wflag cyc=%0d got=%b exp=0", i, write_flag[1]); end
      n_vec++; if (hreadyout[1] !== 1'b1 || hresp[1] !== 1'b0) begin n_err++; $display("FAIL rst_mid_resp cyc=%0d got=%b%b exp=10", i, hreadyout[1], hresp[1]); end
    end
    last_rd[1] = 32'h0; hold_known[1] = 1'b1;
    seq.push_back(mk(32'h40, 1'b0, 3'b010, 32'h0));
    run_seq(1);
  endtask

  task automatic test_ignored();
    @(posedge clk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'b10; haddr[0] = 32'h24; hwrite[0] = 1'b1; hsize[0] = 3'b010;
    @(posedge clk); #1;
    hsel[0] = 1'b1; hready_en[0] = 1'b0; haddr[0] = 32'h28; hwdata[0] = 32'h5A5A_0024;
    #1;
    n_vec++; if (write_flag[0] !== 1'b0 || hreadyout[0] !== 1'b1) begin n_err++; $display("FAIL ignore_hsel got=%b%b exp=01", write_flag[0], hreadyout[0]); end
    @(posedge clk); #1;
    htrans[0] = 2'b00; hready_en[0] = 1'b1; hwdata[0] = 32'h5A5A_0028;
    #1;
    n_vec++; if (write_flag[0] !== 1'b0 || hreadyout[0] !== 1'b1) begin n_err++; $display("FAIL ignore_hready got=%b%b exp=01", write_flag[0], hreadyout[0]); end
    seq.push_back(mk(32'h24, 1'b0, 3'b010, 32'h0));
    seq.push_back(mk(32'h28, 1'b0, 3'b010, 32'h0));
    run_seq(0);
  endtask

  task automatic test_random();
    xfer_t t;
    int r;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 60; i++) begin
        r = $urandom_range(0, 9);
        t = mk(32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)), 3'b010, $urandom);
        if (r == 7) t.addr = 32'h4000 + (32'($urandom_range(0, 15)) << 2);
        if (r == 8) t.addr[1:0] = 2'($urandom_range(1, 3));
        if (r == 9) t.size = 3'($urandom_range(0, 1));
        seq.push_back(t);
      end
      run_seq(k);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4096; i++) ref_mem[k][i] = $urandom;
    load_mem = 1'b1;
    @(posedge clk); #1;
    load_mem = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_pipelined_reads();
    test_errors();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
AHB-Lite subordinate that fronts the team's word-addressed external memory model. It accepts pipelined AHB-Lite address/data phases from the manager, inserts a configurable number of wait states, and drives the memory's read and write strobes, addresses and write data. Read data comes back from the memory's combinational read port. It sits between the interconnect/decoder and the external memory.

Parameters:
WAIT_STATES, 1, HREADYOUT-low cycles inserted at the start of every data phase (0..15)
MEM_DEPTH, 4096, memory size in 32-bit words; word index = HADDR[31:2]
BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
HCLK  in  1  clock, all logic on rising edge
HRESET  in  1  synchronous, active-high reset
HSEL  in  1  slave select from decoder
HADDR  in  32  byte address (address phase)
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  in  1  1=write
HSIZE  in  3  transfer size; only 3'b010 (word) is legal
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus-wide ready (HREADYIN)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  32  read data
READ_addr  out  32  memory word index for reads
read_flag  out  1  memory read enable
mem_rdata  in  32  memory combinational read data
WRITE_addr  out  32  memory word index for writes
write_flag  out  1  memory write enable, committed at rising HCLK
mem_wdata  out  32  write data to memory

Behaviour:
- Reset (HRESET=1 at edge): state IDLE; HREADYOUT=1, HRESP=0, HRDATA=0, read_flag=0, write_flag=0, READ_addr=WRITE_addr=0, mem_wdata=0, wait counter=0.
- Transfer accepted at an edge where HSEL & HREADY & HTRANS[1]; latch word index (HADDR-BASE_ADDR)>>2, HWRITE, legality. BUSY/IDLE: no action, OKAY, zero-wait.
- Legal: HSIZE==010, HADDR[1:0]==00, BASE_ADDR <= HADDR < BASE_ADDR+4*MEM_DEPTH.
- States: IDLE, WAIT, ACCESS, ERR1, ERR2.
- IDLE: legal accept -> WAIT if WAIT_STATES>0 else ACCESS; illegal -> ERR1.
- WAIT: HREADYOUT=0, counter increments; after WAIT_STATES cycles -> ACCESS.
- ACCESS (final data-phase cycle): HREADYOUT=1, HRESP=0. Read: read_flag=1, READ_addr=index, HRDATA=mem_rdata (combinational). Write: write_flag=1, WRITE_addr=index, mem_wdata=HWDATA; memory commits at the edge ending ACCESS. A new accept in this cycle -> WAIT/ACCESS/ERR1 directly (back-to-back pipelining, no bubble).
- ERR1: HREADYOUT=0, HRESP=1, no memory strobe. ERR2: HREADYOUT=1, HRESP=1; transfer accepted in ERR2 is processed normally (manager may also cancel with IDLE).
- read_flag/write_flag are 0 in every state except ACCESS; never both 1.
- Write then read to the same word back-to-back: read returns the new data (write commits before the read's ACCESS cycle).
- HRDATA holds last read value outside read ACCESS.
- HRESET mid-transfer: transfer abandoned, no write strobe issued, all outputs to reset values next cycle.
- Transfers with HSEL=0 or HREADY=0 are ignored; HBURST not decoded (SEQ treated as NONSEQ).

Optional Feature:
Macro AHB_MEM_SLAVE_ERR_RESP_EN. Defined: illegal transfers produce the two-cycle ERROR response above. Undefined: illegal transfers complete as a normal data phase with OKAY, no memory strobe, HRDATA=0; ERR1/ERR2 not built.

Test Plan:
- WAIT_STATES=1: write 32'hDEAD_BEEF to 0x10 -> HREADYOUT low 1 cycle, write_flag=1 with WRITE_addr=4 for one cycle; later read 0x10 -> HRDATA=32'hDEAD_BEEF with HREADYOUT=1.
- Back-to-back NONSEQ write 0x20=32'h1234_5678 then read 0x20 -> read returns 32'h1234_5678, no idle cycle between data phases.
- WAIT_STATES=0, four pipelined reads 0x0,0x4,0x8,0xC -> one transfer completed per cycle, READ_addr 0,1,2,3.
- Access 0x4000 (MEM_DEPTH=4096) with ERR_RESP_EN -> HRESP=1 two cycles, HREADYOUT 0 then 1, write_flag never asserted; without macro -> OKAY, HRDATA=0.
- HSIZE=000 or HADDR=0x13 -> ERROR response (macro on), no strobe.
- HRESET asserted during WAIT of a write -> write_flag never asserts, HREADYOUT=1, HRESP=0 next cycle.
